// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side signals of the round-robin FIFO write arbiter.
// The master modport is the environment (producers plus FIFO status); the
// slave modport is the arbiter itself.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_last;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [WIDTH-1:0]      fifo_wr_data;
  logic [GID_W-1:0]      grant_id;
  logic                  busy;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// A grant lasts until the grantee's last beat or MAX_BURST accepted beats,
// whichever comes first; each new grant costs one arbitration cycle.
// The transfer path is combinational from state, grant_id and the inputs so
// fifo_full gates the write in the same cycle it is seen.
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input logic             clk,
  input logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  localparam int GID_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_t;

  state_t           state;
  logic [GID_W-1:0] grant_id;
  logic [GID_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic             busy;

  logic             arb_found;
  logic [GID_W-1:0] arb_winner;
  logic [GID_W-1:0] cand;

  logic             in_grant;
  logic             g_valid;
  logic             g_last;
  logic [WIDTH-1:0] g_data;
  logic             accept;
  logic             burst_end;

  // Pick the first requester at or after rr_ptr+1 (mod NREQ) with valid high.
  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path through
    // this block can leave a stale value behind (which would infer a latch).
    arb_found  = 1'b0;
    arb_winner = rr_ptr;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GID_W'((int'(rr_ptr) + k) % NREQ);
      if (!arb_found && bus.req_valid[cand]) begin
        arb_found  = 1'b1;
        arb_winner = cand;
      end
    end
  end

  // Select the current grantee's data slice.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == GID_W'(i)) begin
        g_data = bus.req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Reset forces all transfer outputs low, even before the state flops settle.
  assign in_grant  = (state == GRANT) && !rst;
  assign g_valid   = bus.req_valid[grant_id];
  assign g_last    = bus.req_last[grant_id];
  assign accept    = in_grant && g_valid && !bus.fifo_full;
  assign burst_end = (beat_cnt == CNT_W'(MAX_BURST - 1));

  // Only the grantee sees ready, and only while the FIFO has room.
  always_comb begin
    bus.req_ready = '0;
    if (in_grant && !bus.fifo_full) begin
      bus.req_ready[grant_id] = 1'b1;
    end
  end

  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_wr_data = accept ? g_data : '0;
  assign bus.grant_id     = grant_id;
  assign bus.busy         = busy;

  // Arbitration / transfer FSM with registered grant_id and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= GID_W'(NREQ - 1);
      beat_cnt <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge
      // values and updates together, independent of statement order.
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant_id <= arb_winner;
            beat_cnt <= '0;
            state    <= GRANT;
            busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (accept) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            if (g_last || burst_end) begin
              rr_ptr <= grant_id;
              state  <= IDLE;
              busy   <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter. Producers hold valid whenever they
// have queued beats, so the write order follows from the round-robin rules
// alone; a queue-based model turns each phase's packets into the expected
// FIFO write sequence, and a monitor compares every write against it.
module tb_fifo_wr_arbiter;

  localparam int WIDTH     = 8;
  localparam int NREQ      = 4;
  localparam int MAX_BURST = 4;
  localparam int GID_W     = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  typedef struct packed {
    logic [GID_W-1:0] id;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  fifo_wr_arbiter #(
    .WIDTH    (WIDTH),
    .NREQ     (NREQ),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  beat_t src_q[NREQ][$];
  beat_t mq[NREQ][$];
  exp_t  exp_q[$];

  int total = 0;
  int bad = 0;
  int model_ptr = NREQ - 1;
  bit full_en = 1'b0;
  bit bubble_en = 1'b0;
  int phase_busy = 0;
  int phase_writes = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic finish_sim();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic load_beat(input int id, input logic [WIDTH-1:0] d, input bit last);
    beat_t b;
    b.data = d;
    b.last = last;
    src_q[id].push_back(b);
    mq[id].push_back(b);
  endtask

  task automatic load_pkt(input int id, input int len);
    for (int b = 0; b < len; b++) begin
      load_beat(id, WIDTH'($urandom), (b == len - 1));
    end
  endtask

  // Reference: rotate over producers with pending beats, draining one packet
  // (or MAX_BURST beats of it) per grant.
  task automatic model_run();
    int    win;
    int    c;
    int    n;
    beat_t b;
    exp_t  e;
    forever begin
      win = -1;
      for (int k = 1; k <= NREQ; k++) begin
        c = (model_ptr + k) % NREQ;
        if (win < 0 && mq[c].size() > 0) win = c;
      end
      if (win < 0) break;
      n = 0;
      do begin
        b = mq[win].pop_front();
        e.id = GID_W'(win);
        e.data = b.data;
        exp_q.push_back(e);
        n++;
      end while (!b.last && n < MAX_BURST);
      model_ptr = win;
    end
  endtask

  function automatic bit srcs_empty();
    for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_phase(input int budget);
    int c = 0;
    while ((exp_q.size() > 0 || !srcs_empty() || bus.busy) && c < budget) begin
      @(posedge clk);
      #2;
      c++;
    end
    if (c >= budget) begin
      check("phase_timeout", 0, 1);
      finish_sim();
    end
    check("idle_busy", int'(bus.busy), 0);
    check("grant_id_hold", int'(bus.grant_id), model_ptr);
  endtask

  task automatic start_phase();
    phase_busy = 0;
    phase_writes = 0;
  endtask

  // Producer driver: present queue heads at negedge, pop on handshake.
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.fifo_full = 1'b0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (src_q[i].size() > 0) begin
          bus.req_data[i*WIDTH +: WIDTH] = src_q[i][0].data;
          bus.req_last[i] = src_q[i][0].last;
          bus.req_valid[i] = !(bubble_en && bus.busy &&
                               bus.grant_id == GID_W'(i) &&
                               $urandom_range(0, 2) == 0);
        end else begin
          bus.req_valid[i] = 1'b0;
          bus.req_last[i] = 1'b0;
        end
      end
      bus.fifo_full = full_en && ($urandom_range(0, 3) == 0);
      #4;
      if (!rst) begin
        for (int i = 0; i < NREQ; i++) begin
          if (bus.req_valid[i] && bus.req_ready[i]) void'(src_q[i].pop_front());
        end
      end
    end
  end

  // Monitor: check every cycle just before the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        if (bus.busy) phase_busy++;
        if (bus.fifo_full) check("full_blocks", int'({bus.fifo_wr_en, bus.req_ready}), 0);
        check("ready_onehot", int'($countones(bus.req_ready) <= 1), 1);
        check("wr_en_handshake", int'(bus.fifo_wr_en), int'(|(bus.req_valid & bus.req_ready)));
        if (bus.fifo_wr_en) begin
          phase_writes++;
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("wr_data", int'(bus.fifo_wr_data), int'(e.data));
            check("wr_grant_id", int'(bus.grant_id), int'(e.id));
            check("ready_grantee", int'(bus.req_ready), 1 << e.id);
          end
        end
      end
    end
  end

  // Main sequence.
  initial begin
    int waited;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("rst_grant_id", int'(bus.grant_id), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ready", int'(bus.req_ready), 0);
    check("rst_wr_en", int'(bus.fifo_wr_en), 0);
    check("rst_wr_data", int'(bus.fifo_wr_data), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #2;

    // All four request, 2-beat packets: grants 0,1,2,3,0.
    start_phase();
    for (int i = 0; i < NREQ; i++) load_pkt(i, 2);
    load_pkt(0, 2);
    model_run();
    run_phase(500);
    check("rot_busy", phase_busy, 10);
    check("rot_writes", phase_writes, 10);

    // Requester 1 6-beat packet splits at MAX_BURST around requester 3.
    start_phase();
    load_pkt(1, 6);
    load_pkt(3, 2);
    model_run();
    run_phase(500);
    check("split_writes", phase_writes, 8);
    check("split_busy", phase_busy, 8);

    // Requester 2 alone, 3 beats.
    start_phase();
    load_beat(2, 8'hA1, 1'b0);
    load_beat(2, 8'hA2, 1'b0);
    load_beat(2, 8'hA3, 1'b1);
    model_run();
    run_phase(500);
    check("single_busy", phase_busy, 3);
    check("single_writes", phase_writes, 3);

    // Randomized phases with optional FIFO back-pressure and grantee bubbles.
    for (int p = 0; p < 40; p++) begin
      start_phase();
      full_en = 1'($urandom_range(0, 1));
      bubble_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 1) == 1) begin
          for (int n = 0; n < int'($urandom_range(1, 3)); n++) load_pkt(i, int'($urandom_range(1, 7)));
        end
      end
      model_run();
      run_phase(3000);
      if (!full_en && !bubble_en) check("rand_busy_eq_writes", phase_busy, phase_writes);
    end
    full_en = 1'b0;
    bubble_en = 1'b0;
    @(posedge clk);
    #2;

    // Reset during beat 2 of a 4-beat packet from requester 0.
    start_phase();
    load_pkt(0, 4);
    model_run();
    waited = 0;
    while (phase_writes < 1 && waited < 50) begin
      @(posedge clk);
      #2;
      waited++;
    end
    check("rst_mid_first_beat", phase_writes, 1);
    @(negedge clk);
    #1;
    check("pre_rst_wr_en", int'(bus.fifo_wr_en), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_wr_en", int'(bus.fifo_wr_en), 0);
    check("mid_rst_ready", int'(bus.req_ready), 0);
    check("mid_rst_wr_data", int'(bus.fifo_wr_data), 0);
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    model_ptr = NREQ - 1;
    repeat (2) @(negedge clk);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_grant_id", int'(bus.grant_id), 0);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    // After reset every requester valid: requester 0 wins first.
    start_phase();
    for (int i = 0; i < NREQ; i++) load_pkt(i, 1);
    model_run();
    run_phase(500);
    check("post_rst_writes", phase_writes, 4);

    finish_sim();
  end

endmodule
